timer_run_ctrl: RTL and testbench

Run/mode sequencer for the two-mode timer. Conditions the StartStop button and ModeSel switch, owns the Idle/Run/Pause/Done state machine, and generates the 100 Hz count-enable tick. It drives the BCD counter datapath through clear, load, enable and direction strobes, and drives the display DOT. It sits between the board I/O and the counter/7-segment datapath inside the timer top level.

---
 rtl/timer_run_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_timer_run_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_run_ctrl.sv
// Run/mode sequencer for the two-mode timer: input conditioning, the
// Init/Idle/Run/Pause/Done state machine, the count-tick divider and the
// DONE blink of the display DOT. All outputs are registered.

module timer_run_ctrl #(
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned BLINK_TICKS = 25
) (
  input  logic CLK_50MHz,
  input  logic rst,
  input  logic StartStop,
  input  logic ModeSel,
  input  logic cnt_zero,
  input  logic cnt_max,
  output logic cnt_clr,
  output logic cnt_load,
  output logic cnt_en,
  output logic cnt_up,
  output logic running,
  output logic done,
  output logic dot
);

  // Blink period is measured in clock cycles so one counter covers it.
  localparam int unsigned BlinkPeriod = TICK_DIV * BLINK_TICKS;
  localparam int unsigned DivW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DbW         = $clog2(DB_CYCLES + 1);
  localparam int unsigned BlinkW      = (BlinkPeriod > 1) ? $clog2(BlinkPeriod) : 1;

  localparam logic [DivW-1:0]   DivLast   = DivW'(TICK_DIV - 1);
  localparam logic [DbW-1:0]    DbLast    = DbW'(DB_CYCLES - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BlinkPeriod - 1);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic ss_meta, ss_sync;
  logic ms_meta, ms_sync, ms_prev;
  logic db_level;
  logic [DbW-1:0] db_cnt;
  logic press_evt;
  logic [DivW-1:0] div_q;
  logic [BlinkW-1:0] blink_q;

  logic mode_evt;
  logic mode_b;
  logic tick;
  logic at_limit;
  logic blink_wrap;
  logic step_en;
  logic dot_d;

  // Two-flop synchronizers for both raw inputs, plus the previous synced mode.
  always_ff @(posedge CLK_50MHz or posedge rst) begin
    if (rst) begin
      ss_meta <= 1'b0;
      ss_sync <= 1'b0;
      ms_meta <= 1'b0;
      ms_sync <= 1'b0;
      ms_prev <= 1'b0;
    end else begin
      ss_meta <= StartStop;
      ss_sync <= ss_meta;
      ms_meta <= ModeSel;
      ms_sync <= ms_meta;
      ms_prev <= ms_sync;
    end
  end

  // Debounce StartStop; press_evt pulses in the cycle after the level rises.
  always_ff @(posedge CLK_50MHz or posedge rst) begin
    if (rst) begin
      db_level  <= 1'b0;
      db_cnt    <= '0;
      press_evt <= 1'b0;
    end else if (ss_sync == db_level) begin
      db_cnt    <= '0;
      press_evt <= 1'b0;
    end else if (db_cnt == DbLast) begin
      db_level  <= ss_sync;
      db_cnt    <= '0;
      press_evt <= ss_sync;
    end else begin
      db_cnt    <= db_cnt + 1'b1;
      press_evt <= 1'b0;
    end
  end

  // Event decode shared by the FSM and the dividers.
  always_comb begin
    mode_evt   = (ms_sync != ms_prev);
    mode_b     = ms_sync;
    tick       = (state_q == StRun) && (div_q == DivLast);
    at_limit   = mode_b ? cnt_zero : cnt_max;
    blink_wrap = (state_q == StDone) && (blink_q == BlinkLast);
  end

  // Tick divider: counts in RUN, holds in PAUSE so a partial interval survives.
  always_ff @(posedge CLK_50MHz or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      unique case (state_q)
        StRun:   div_q <= tick ? '0 : div_q + 1'b1;
        StPause: div_q <= div_q;
        default: div_q <= '0;
      endcase
    end
  end

  // Blink divider: runs only in DONE, wraps once per DOT half-period.
  always_ff @(posedge CLK_50MHz or posedge rst) begin
    if (rst) begin
      blink_q <= '0;
    end else if (state_q == StDone) begin
      blink_q <= (blink_q == BlinkLast) ? '0 : blink_q + 1'b1;
    end else begin
      blink_q <= '0;
    end
  end

  // Next-state decode; a mode event outranks a press in the same cycle.
  always_comb begin
    state_d = state_q;
    step_en = 1'b0;
    unique case (state_q)
      StInit: state_d = StIdle;
      StIdle: begin
        if (mode_evt) begin
          state_d = StInit;
        end else if (press_evt) begin
          state_d = (mode_b && cnt_zero) ? StDone : StRun;
        end
      end
      StRun: begin
        if (mode_evt) begin
          state_d = StInit;
        end else if (press_evt) begin
          state_d = StPause;
        end else if (tick) begin
          // Terminal count: stop without stepping, so Mode A saturates at 99.99.
          if (at_limit) begin
            state_d = StDone;
          end else begin
            step_en = 1'b1;
          end
        end
      end
      StPause: begin
        if (mode_evt) begin
          state_d = StInit;
        end else if (press_evt) begin
          state_d = StRun;
        end
      end
      StDone: begin
        if (mode_evt || press_evt) begin
          state_d = StInit;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // DOT value for the upcoming state; DONE starts lit, then blinks.
  always_comb begin
    dot_d = 1'b0;
    case (state_d)
      StRun, StPause: dot_d = 1'b1;
      StDone: begin
        if (state_q != StDone) begin
          dot_d = 1'b1;
        end else begin
          dot_d = blink_wrap ? ~dot : dot;
        end
      end
      default: dot_d = 1'b0;
    endcase
  end

  // State register and registered outputs; strobes default low every cycle.
  always_ff @(posedge CLK_50MHz or posedge rst) begin
    if (rst) begin
      state_q  <= StInit;
      cnt_clr  <= 1'b0;
      cnt_load <= 1'b0;
      cnt_en   <= 1'b0;
      cnt_up   <= 1'b1;
      running  <= 1'b0;
      done     <= 1'b0;
      dot      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_clr  <= (state_q == StInit) && !mode_b;
      cnt_load <= (state_q == StInit) && mode_b;
      cnt_en   <= step_en;
      cnt_up   <= ~ms_sync;
      running  <= (state_d == StRun);
      done     <= (state_d == StDone);
      dot      <= dot_d;
    end
  end

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Bench for timer_run_ctrl: a cycle-level behavioural model predicts every
// output each cycle, and directed scenarios pin the model with literal counts.

module tb_timer_run_ctrl;

  localparam int TickDiv    = 10;
  localparam int DbCycles   = 2;
  localparam int BlinkTicks = 2;
  localparam int BlinkCyc   = TickDiv * BlinkTicks;

  localparam int PInit  = 0;
  localparam int PIdle  = 1;
  localparam int PRun   = 2;
  localparam int PPause = 3;
  localparam int PDone  = 4;

  logic clk;
  logic rst;
  logic StartStop;
  logic ModeSel;
  logic cnt_zero;
  logic cnt_max;
  logic cnt_clr;
  logic cnt_load;
  logic cnt_en;
  logic cnt_up;
  logic running;
  logic done;
  logic dot;

  int n_cmp = 0;
  int n_bad = 0;

  timer_run_ctrl #(
    .TICK_DIV   (TickDiv),
    .DB_CYCLES  (DbCycles),
    .BLINK_TICKS(BlinkTicks)
  ) dut (
    .CLK_50MHz(clk),
    .rst      (rst),
    .StartStop(StartStop),
    .ModeSel  (ModeSel),
    .cnt_zero (cnt_zero),
    .cnt_max  (cnt_max),
    .cnt_clr  (cnt_clr),
    .cnt_load (cnt_load),
    .cnt_en   (cnt_en),
    .cnt_up   (cnt_up),
    .running  (running),
    .done     (done),
    .dot      (dot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic ss_h [2];   // raw StartStop seen 1 and 2 edges ago
  logic ms_h [3];   // raw ModeSel 1, 2 edges ago, and the synced value before that
  int   m_phase;
  logic m_level;
  logic m_streak_val;
  int   m_streak_len;
  logic m_press;
  int   m_run_cycles;
  int   m_done_cycles;
  logic e_clr, e_load, e_en, e_up, e_run, e_done, e_dot;

  task automatic model_reset();
    ss_h[0] = 1'b0; ss_h[1] = 1'b0;
    ms_h[0] = 1'b0; ms_h[1] = 1'b0; ms_h[2] = 1'b0;
    m_phase = PInit;
    m_level = 1'b0;
    m_streak_val = 1'b0;
    m_streak_len = 0;
    m_press = 1'b0;
    m_run_cycles = 0;
    m_done_cycles = 0;
    e_clr = 1'b0; e_load = 1'b0; e_en = 1'b0; e_up = 1'b1;
    e_run = 1'b0; e_done = 1'b0; e_dot = 1'b0;
  endtask

  task automatic model_step();
    logic s_ss, s_ms, mevt, tick, stop;
    int nxt;
    s_ss = ss_h[1];
    s_ms = ms_h[1];
    mevt = (ms_h[1] != ms_h[2]);
    tick = (m_phase == PRun) && ((m_run_cycles % TickDiv) == TickDiv - 1);
    e_clr  = (m_phase == PInit) && !s_ms;
    e_load = (m_phase == PInit) && s_ms;
    e_en   = 1'b0;
    e_up   = !s_ms;
    nxt = m_phase;
    if (m_phase == PInit) nxt = PIdle;
    else if (mevt) nxt = PInit;
    else if (m_press) begin
      case (m_phase)
        PIdle:  nxt = (s_ms && cnt_zero) ? PDone : PRun;
        PRun:   nxt = PPause;
        PPause: nxt = PRun;
        default: nxt = PInit;
      endcase
    end else if (tick) begin
      stop = s_ms ? cnt_zero : cnt_max;
      if (stop) nxt = PDone;
      else e_en = 1'b1;
    end
    if (nxt == PRun || nxt == PPause) e_dot = 1'b1;
    else if (nxt == PDone) begin
      if (m_phase != PDone) e_dot = 1'b1;
      else e_dot = (((m_done_cycles + 1) / BlinkCyc) % 2) == 0;
    end else e_dot = 1'b0;
    e_run  = (nxt == PRun);
    e_done = (nxt == PDone);
    if (m_phase == PRun) m_run_cycles++;
    else if (m_phase != PPause) m_run_cycles = 0;
    if (m_phase == PDone) m_done_cycles++;
    else m_done_cycles = 0;
    m_phase = nxt;
    // Debounce: accept a level once it has been seen DbCycles times running.
    if (s_ss == m_streak_val) m_streak_len++;
    else begin
      m_streak_val = s_ss;
      m_streak_len = 1;
    end
    m_press = 1'b0;
    if (m_streak_len >= DbCycles && m_streak_val != m_level) begin
      m_level = m_streak_val;
      m_press = m_level;
    end
    ss_h[1] = ss_h[0]; ss_h[0] = StartStop;
    ms_h[2] = ms_h[1]; ms_h[1] = ms_h[0]; ms_h[0] = ModeSel;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic [6:0] got, exp;
    forever begin
      @(negedge clk);
      got = {cnt_clr, cnt_load, cnt_en, cnt_up, running, done, dot};
      exp = {e_clr, e_load, e_en, e_up, e_run, e_done, e_dot};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t {clr,load,en,up,run,done,dot} got %b expected %b",
                 $time, got, exp);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    StartStop = 1'b1;
    cyc(4);
    StartStop = 1'b0;
  endtask

  task automatic run_count(input int n, output int clr_n, output int load_n, output int en_n);
    clr_n = 0; load_n = 0; en_n = 0;
    repeat (n) begin
      @(negedge clk);
      clr_n  += int'(cnt_clr);
      load_n += int'(cnt_load);
      en_n   += int'(cnt_en);
    end
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge where cnt_en is seen; n = -1 on timeout.
  task automatic wait_en(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cnt_en && n < limit);
    if (!cnt_en) n = -1;
  endtask

  task automatic wait_dot_change(input int limit, output int n);
    logic prev;
    prev = dot;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dot == prev && n < limit);
    if (dot == prev) n = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int c, l, e, n;
    rst = 1'b0; StartStop = 1'b0; ModeSel = 1'b0; cnt_zero = 1'b0; cnt_max = 1'b0;
    #1 rst = 1'b1;
    cyc(5);
    check("reset_cnt_up", int'(cnt_up), 1);
    check("reset_running", int'(running), 0);
    rst = 1'b0;
    run_count(5, c, l, e);
    check("init_clr_pulses", c, 1);
    check("init_load_pulses", l, 0);
    check("idle_dot", int'(dot), 0);

    // Mode A: run, five evenly spaced steps
    press();
    cyc(2);
    check("runA_running", int'(running), 1);
    wait_en(20, n);
    check("first_en_latency", n, 10);
    for (int i = 0; i < 4; i++) begin
      wait_en(20, n);
      check("en_spacing", n, 10);
    end

    // One-cycle glitch must not be taken as a press
    @(posedge clk); #1;
    StartStop = 1'b1;
    cyc(1);
    StartStop = 1'b0;
    cyc(8);
    check("glitch_still_running", int'(running), 1);

    // Pause, then resume with a partial interval kept
    press();
    cyc(2);
    check("pause_running", int'(running), 0);
    check("pause_dot", int'(dot), 1);
    run_count(50, c, l, e);
    check("pause_no_en", e, 0);
    press();
    wait_en(20, n);
    check("resume_partial_interval", int'(n >= 2 && n <= 9), 1);

    // Mode A saturation at 99.99
    cnt_max = 1'b1;
    run_count(15, c, l, e);
    check("sat_no_en", e, 0);
    check("sat_done", int'(done), 1);
    check("sat_running", int'(running), 0);
    wait_dot_change(40, n);
    check("blink_first_toggle_seen", int'(n > 0), 1);
    wait_dot_change(40, n);
    check("blink_period_a", n, 20);
    wait_dot_change(40, n);
    check("blink_period_b", n, 20);
    @(posedge clk); #1;
    cnt_max = 1'b0;

    // Mode B: mode change re-preps with a load
    ModeSel = 1'b1;
    run_count(8, c, l, e);
    check("modeB_load_pulses", l, 1);
    check("modeB_clr_pulses", c, 0);
    check("modeB_cnt_up", int'(cnt_up), 0);
    check("modeB_done_cleared", int'(done), 0);

    // Press in IDLE with the counter already at zero goes straight to DONE
    cnt_zero = 1'b1;
    press();
    cyc(2);
    check("idle_zero_done", int'(done), 1);
    cnt_zero = 1'b0;
    press();
    run_count(6, c, l, e);
    check("done_press_reload", l, 1);

    // Countdown until zero
    press();
    cyc(2);
    check("runB_running", int'(running), 1);
    wait_en(20, n);
    check("runB_first_en", n, 10);
    cnt_zero = 1'b1;
    run_count(15, c, l, e);
    check("zero_no_en", e, 0);
    check("zero_done", int'(done), 1);
    press();
    run_count(6, c, l, e);
    check("zero_press_load", l, 1);
    check("zero_press_idle", int'(running | done), 0);
    cnt_zero = 1'b0;

    // Mode event and press event in the same cycle during RUN
    press();
    cyc(2);
    check("simul_pre_running", int'(running), 1);
    StartStop = 1'b1;
    cyc(2);
    ModeSel = 1'b0;
    cyc(2);
    StartStop = 1'b0;
    run_count(10, c, l, e);
    check("simul_clr_pulses", c, 1);
    check("simul_no_en", e, 0);
    cyc(10);
    check("simul_rests_idle", int'(running), 0);

    // Asynchronous reset in the middle of RUN, with a step pulse in flight
    press();
    wait_en(20, n);
    check("prereset_en_seen", int'(n > 0), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_en", int'(cnt_en), 0);
    check("async_rst_running", int'(running), 0);
    check("async_rst_dot", int'(dot), 0);
    cyc(2);
    rst = 1'b0;
    run_count(5, c, l, e);
    check("post_reset_clr", c, 1);
    check("post_reset_idle", int'(running), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
